// File: rtl/gcm_ae_hw_deadlock_reporter_if.sv
// Report handshake bundle between the deadlock reporter and its consumer.
// The reporter drives valid/data; the consumer drives ready.
interface gcm_ae_hw_deadlock_reporter_if #(
  parameter int RPT_W = 42
) ();
  logic             report_valid;
  logic             report_ready;
  logic [RPT_W-1:0] report_data;

  modport master (
    output report_valid,
    output report_data,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_data,
    output report_ready
  );
endinterface

// File: rtl/gcm_ae_hw_deadlock_reporter.sv
// Deadlock reporter for the GCM_AE_HW_1x4 per-instance monitors.
// Confirms a deadlock once any monitor block flag persists for THRESH
// consecutive cycles, latches a one-shot report {snapshot, lowest index, ts}
// and offers it on a valid/ready handshake. The sticky deadlock flag holds
// until clear is pulsed after the report has been taken.
// Optional feature macro: GCM_DEADLOCK_TIMESTAMP_EN adds a free-running 32-bit
// timestamp whose value at declaration fills report_data[31:0]; without it that
// field is tied to zero and the port widths are unchanged.
module gcm_ae_hw_deadlock_reporter #(
  parameter int N_MON  = 7,
  parameter int IDX_W  = 3,
  parameter int THRESH = 16,
  parameter int CNT_W  = 16,
  parameter int RPT_W  = N_MON + IDX_W + 32
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_MON-1:0]              block_sigs,
  input  logic                          clear,
  output logic                          deadlock,
  output logic [7:0]                    dl_count,
  gcm_ae_hw_deadlock_reporter_if.master rpt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             report_valid_q;
  logic [RPT_W-1:0] report_data_q;
  logic [31:0]      ts_now;
  logic             any_block;

  assign any_block = |block_sigs;

  // Lowest set bit of the block vector; zero when nothing is blocked.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_MON-1:0] v);
    lowest_idx = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

`ifdef GCM_DEADLOCK_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  // Free-running timestamp; wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 32'd1;
  end

  assign ts_now = ts_cnt;
`else
  assign ts_now = '0;
`endif

  // Persistence watch, report latch and sticky flag in one registered FSM.
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of each other; a blocking = would let later lines read updated state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the report register is cleared too, so a report pending at
      // reset is deliberately lost rather than replayed afterwards.
      state          <= IDLE;
      cnt            <= '0;
      deadlock       <= 1'b0;
      report_valid_q <= 1'b0;
      report_data_q  <= '0;
      dl_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            cnt <= '0;
          end else if (any_block) begin
            state <= WATCH;
            cnt   <= CNT_W'(1);
          end
        end

        WATCH: begin
          if (clear || !any_block) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state          <= REPORT;
            cnt            <= '0;
            deadlock       <= 1'b1;
            report_valid_q <= 1'b1;
            report_data_q  <= {block_sigs, lowest_idx(block_sigs), ts_now};
            if (dl_count != 8'hFF) dl_count <= dl_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Clear and block inputs are ignored until the report is taken.
        REPORT: begin
          if (rpt.report_ready) begin
            state          <= HOLD;
            report_valid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (clear) begin
            state    <= IDLE;
            cnt      <= '0;
            deadlock <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign rpt.report_valid = report_valid_q;
  assign rpt.report_data  = report_data_q;

endmodule

// File: doc/gcm_ae_hw_deadlock_reporter.md
# gcm_ae_hw_deadlock_reporter

Consumer side of the per-instance deadlock monitors in the GCM_AE_HW_1x4 design. Takes the registered `block` outputs of up to N_MON monitors, confirms a deadlock once any block persists for THRESH consecutive cycles, and latches a one-shot report: a snapshot of the block vector, the lowest blocked index and an optional timestamp. The report goes out on a valid/ready handshake, and a sticky `deadlock` flag holds until software or the testbench clears it.

## Interface
- N_MON, 7, number of monitor block inputs (1..32)
- IDX_W, 3, width of blocked-index field; ceil(log2(N_MON)), minimum 1
- THRESH, 16, consecutive blocked cycles needed to declare deadlock (2..65535)
- CNT_W, 16, persistence counter width; must hold THRESH-1
- RPT_W, N_MON+IDX_W+32, report width (derived, not overridden)

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- block_sigs  in  N_MON  registered block flags from the monitors; bit i = monitor i
- clear  in  1  synchronous pulse; releases sticky state
- deadlock  out  1  sticky deadlock flag
- report_valid  out  1  report available
- report_ready  in  1  downstream accepts report
- report_data  out  RPT_W  {snapshot[N_MON-1:0], idx[IDX_W-1:0], ts[31:0]}
- dl_count  out  8  number of declared deadlocks, saturating at 255

## Operation
- any_block = OR of block_sigs.
- States: IDLE, WATCH, REPORT, HOLD. cnt is CNT_W bits.
- IDLE: cnt=0. If any_block, go to WATCH with cnt=1.
- WATCH:
  - If !any_block, go to IDLE with cnt=0.
  - Else if cnt==THRESH-1, go to REPORT. Capture snapshot=block_sigs, idx=lowest set bit of block_sigs, ts=current timestamp. Increment dl_count (saturating).
  - Else cnt++.
- REPORT: report_valid=1 and deadlock=1. report_data is stable until the handshake (report_valid & report_ready at an edge), then go to HOLD. clear is ignored in REPORT.
- HOLD: deadlock=1, report_valid=0. On clear, go to IDLE with cnt=0. Block inputs are ignored in HOLD.
- clear in IDLE or WATCH forces IDLE with cnt=0, and takes priority over counting. dl_count is only reset by reset_n.
- Block bits that change while in WATCH do not restart the count, as long as any_block stays high.

## Timing
- Reset values: state=IDLE, cnt=0, deadlock=0, report_valid=0, report_data=0, dl_count=0, timestamp=0.
- Declaration latency:
  - any_block high at THRESH consecutive rising edges e1..eTHRESH puts the block in REPORT after eTHRESH.
  - deadlock and report_valid go high in the cycle following eTHRESH.
  - A single low sample resets the sequence.
- The handshake completes in the same cycle that report_ready is high. report_valid falls after that edge. report_ready held high gives a 1-cycle valid pulse.
- clear in HOLD gives deadlock=0 after that edge. The earliest next declaration is THRESH edges later.
- The timestamp is a free-running 32-bit counter that wraps 0xFFFFFFFF to 0. ts captures its value at edge eTHRESH, before the increment.
- reset_n asserted mid-operation, including mid-REPORT, immediately forces all reset values. A pending report is lost.

## Configuration
- GCM_DEADLOCK_TIMESTAMP_EN defined: the 32-bit timestamp counter is instantiated and report_data[31:0]=ts.
- Undefined: no counter is instantiated and report_data[31:0] is tied to 0. Port widths are unchanged.

## Test plan
- Reset with THRESH=16, then block_sigs=7'b0000100 held for 16 cycles: deadlock=1 and report_valid=1 the cycle after the 16th edge; snapshot=7'b0000100, idx=2, dl_count=1.
- block_sigs=7'b0100000 for 15 cycles, 0 for 1 cycle, then high again for 15 cycles: no deadlock and report_valid stays 0.
- Deadlock with block_sigs=7'b0101010 and report_ready=0 for 10 cycles: report_data constant and valid held. Then ready=1 for 1 cycle: valid drops and state is HOLD with deadlock=1.
- clear pulsed in REPORT: no effect. clear pulsed in HOLD: deadlock=0 next cycle, and a fresh 16-cycle block yields dl_count=2.
- With GCM_DEADLOCK_TIMESTAMP_EN, release reset at cycle 0 and assert a block continuously from cycle 4: ts=19 (edge 4+15). Without the macro: ts field=0.
- Assert reset_n low mid-REPORT: deadlock, report_valid and dl_count are 0 immediately (asynchronously), and the block is in IDLE after release.
